// File: rtl/mult_div_unit.sv
// Multiply/divide unit with HI/LO registers and a fixed-latency busy counter.
// Optional macro MDU_CANCEL_EN adds a cancel input that flushes an in-flight op.
module mult_div_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic             clk,
    input  logic             reset,
`ifdef MDU_CANCEL_EN
    input  logic             cancel,
`endif
    input  logic             start,
    input  logic [3:0]       mdu_op,
    input  logic [WIDTH-1:0] rs_val,
    input  logic [WIDTH-1:0] rt_val,
    output logic             busy,
    output logic             stall_req,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] mf_data
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;
    logic [WIDTH-1:0] r_pend_hi;
    logic [WIDTH-1:0] r_pend_lo;
    logic             r_pend_wr;

    logic             w_cancel;
    logic             w_is_arith;
    logic             w_accept;
    logic             w_mt_ok;

    logic [2*WIDTH-1:0] w_rs_sx;
    logic [2*WIDTH-1:0] w_rt_sx;
    logic [2*WIDTH-1:0] w_prod_s;
    logic [2*WIDTH-1:0] w_prod_u;
    logic [WIDTH-1:0]   w_divisor;
    logic [WIDTH-1:0]   w_quot_s;
    logic [WIDTH-1:0]   w_rem_s;
    logic [WIDTH-1:0]   w_quot_u;
    logic [WIDTH-1:0]   w_rem_u;
    logic               w_div0;
    logic               w_div_ovf;

    logic [WIDTH-1:0]   w_pend_hi;
    logic [WIDTH-1:0]   w_pend_lo;
    logic               w_pend_wr;
    logic [CNT_W-1:0]   w_cycles;

`ifdef MDU_CANCEL_EN
    assign w_cancel = cancel;
`else
    assign w_cancel = 1'b0;
`endif

    // Handshake: an op issues when start is high. An arithmetic op is taken
    // only while !busy; stall_req tells the hazard unit to hold the issuing
    // instruction (including in its own accept cycle) and anything behind it.
    assign w_is_arith = start && (mdu_op >= OP_MULT) && (mdu_op <= OP_DIVU);
    assign w_accept   = w_is_arith && !busy;
    assign w_mt_ok    = start && !busy;

    assign busy      = (r_cnt != '0);
    assign stall_req = busy || w_is_arith;
    assign hi        = r_hi;
    assign lo        = r_lo;
    assign mf_data   = (start && mdu_op == OP_MFHI) ? r_hi :
                       (start && mdu_op == OP_MFLO) ? r_lo : '0;

    // Low 2*WIDTH bits of the sign-extended product equal the signed product.
    assign w_rs_sx  = {{WIDTH{rs_val[WIDTH-1]}}, rs_val};
    assign w_rt_sx  = {{WIDTH{rt_val[WIDTH-1]}}, rt_val};
    assign w_prod_s = w_rs_sx * w_rt_sx;
    assign w_prod_u = {{WIDTH{1'b0}}, rs_val} * {{WIDTH{1'b0}}, rt_val};

    assign w_div0    = (rt_val == '0);
    assign w_div_ovf = (rs_val == {1'b1, {(WIDTH-1){1'b0}}}) && (rt_val == '1);
    // Divisor forced to 1 on zero so the dividers never see x; result is discarded anyway.
    assign w_divisor = w_div0 ? {{(WIDTH-1){1'b0}}, 1'b1} : rt_val;
    assign w_quot_s  = $signed(rs_val) / $signed(w_divisor);
    assign w_rem_s   = $signed(rs_val) % $signed(w_divisor);
    assign w_quot_u  = rs_val / w_divisor;
    assign w_rem_u   = rs_val % w_divisor;

    always_comb begin
        w_pend_hi = '0;
        w_pend_lo = '0;
        w_pend_wr = 1'b0;
        w_cycles  = CNT_W'(MULT_CYCLES);
        case (mdu_op)
            OP_MULT: begin
                {w_pend_hi, w_pend_lo} = w_prod_s;
                w_pend_wr = 1'b1;
            end
            OP_MULTU: begin
                {w_pend_hi, w_pend_lo} = w_prod_u;
                w_pend_wr = 1'b1;
            end
            OP_DIV: begin
                w_cycles  = CNT_W'(DIV_CYCLES);
                w_pend_wr = !w_div0;
                w_pend_lo = w_div_ovf ? rs_val : w_quot_s;
                w_pend_hi = w_div_ovf ? '0 : w_rem_s;
            end
            OP_DIVU: begin
                w_cycles  = CNT_W'(DIV_CYCLES);
                w_pend_wr = !w_div0;
                w_pend_lo = w_quot_u;
                w_pend_hi = w_rem_u;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_pend_hi <= '0;
            r_pend_lo <= '0;
            r_pend_wr <= 1'b0;
        end else if (w_cancel) begin
            r_cnt     <= '0;
            r_pend_wr <= 1'b0;
        end else if (r_cnt > CNT_W'(1)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end else if (r_cnt == CNT_W'(1)) begin
            r_cnt     <= '0;
            r_pend_wr <= 1'b0;
            if (r_pend_wr) begin
                r_hi <= r_pend_hi;
                r_lo <= r_pend_lo;
            end
        end else if (w_accept) begin
            r_cnt     <= w_cycles;
            r_pend_hi <= w_pend_hi;
            r_pend_lo <= w_pend_lo;
            r_pend_wr <= w_pend_wr;
        end else if (w_mt_ok && mdu_op == OP_MTHI) begin
            r_hi <= rs_val;
        end else if (w_mt_ok && mdu_op == OP_MTLO) begin
            r_lo <= rs_val;
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Directed bench for mult_div_unit: latency, HI/LO results, busy-time ignores,
// reset flush and (with MDU_CANCEL_EN) cancel.
module tb_mult_div_unit;

    localparam int W = 32;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [3:0]   mdu_op;
    logic [W-1:0] rs_val;
    logic [W-1:0] rt_val;
    logic         busy;
    logic         stall_req;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic [W-1:0] mf_data;
`ifdef MDU_CANCEL_EN
    logic         cancel;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [W-1:0] exp_q[$];

    mult_div_unit dut (
        .clk       (clk),
        .reset     (reset),
`ifdef MDU_CANCEL_EN
        .cancel    (cancel),
`endif
        .start     (start),
        .mdu_op    (mdu_op),
        .rs_val    (rs_val),
        .rt_val    (rt_val),
        .busy      (busy),
        .stall_req (stall_req),
        .hi        (hi),
        .lo        (lo),
        .mf_data   (mf_data)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_hilo(input logic [W-1:0] eh, input logic [W-1:0] el);
        exp_q.push_back(eh);
        exp_q.push_back(el);
    endtask

    task automatic check_hilo(input string tag);
        logic [W-1:0] eh;
        logic [W-1:0] el;
        eh = exp_q.pop_front();
        el = exp_q.pop_front();
        check_eq({tag, ".hi"}, hi, eh);
        check_eq({tag, ".lo"}, lo, el);
    endtask

    // driver tasks
    task automatic step();
        @(negedge clk);
    endtask

    task automatic release_inputs();
        start  = 1'b0;
        mdu_op = 4'd0;
        rs_val = '0;
        rt_val = '0;
    endtask

    task automatic drive(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        start  = 1'b1;
        mdu_op = op;
        rs_val = a;
        rt_val = b;
    endtask

    task automatic issue(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic exp_stall);
        drive(op, a, b);
        #1;
        check_eq({tag, ".stall_accept"}, stall_req, exp_stall);
        step();
        release_inputs();
    endtask

    task automatic wait_idle(output int cycles, output int stall_bad);
        cycles    = 0;
        stall_bad = 0;
        while (busy && cycles < 100) begin
            if (stall_req !== 1'b1) stall_bad++;
            cycles++;
            step();
        end
    endtask

    initial begin
        int c;
        int sb;
        int c0;
        reset = 1'b1;
        release_inputs();
`ifdef MDU_CANCEL_EN
        cancel = 1'b0;
`endif
        step();
        step();
        reset = 1'b0;
        check_eq("reset.busy", busy, 0);
        check_eq("reset.stall", stall_req, 0);
        check_eq("reset.hi", hi, 0);
        check_eq("reset.lo", lo, 0);

        // 1: MULT signed
        issue("mult", OP_MULT, 32'hFFFF_FFFE, 32'd3, 1'b1);
        check_eq("mult.pending_hidden", lo, 0);
        wait_idle(c, sb);
        check_eq("mult.busy_cycles", c, 5);
        check_eq("mult.stall_busy", sb, 0);
        expect_hilo(32'hFFFF_FFFF, 32'hFFFF_FFFA);
        check_hilo("mult");

        drive(OP_MFHI, 0, 0);
        #1;
        check_eq("mfhi.data", mf_data, 32'hFFFF_FFFF);
        check_eq("mfhi.no_stall", stall_req, 0);
        mdu_op = OP_MFLO;
        #1;
        check_eq("mflo.data", mf_data, 32'hFFFF_FFFA);
        step();
        release_inputs();

        // 2: MULTU
        issue("multu", OP_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b1);
        wait_idle(c, sb);
        check_eq("multu.busy_cycles", c, 5);
        expect_hilo(32'h0000_0002, 32'hFFFF_FFFA);
        check_hilo("multu");

        // 3: DIV signed, then overflow corner
        issue("div", OP_DIV, 32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_idle(c, sb);
        check_eq("div.busy_cycles", c, 10);
        check_eq("div.stall_busy", sb, 0);
        expect_hilo(32'hFFFF_FFFF, 32'hFFFF_FFFD);
        check_hilo("div");

        issue("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
        wait_idle(c, sb);
        expect_hilo(32'h0000_0000, 32'h8000_0000);
        check_hilo("div_ovf");

        // 4: MTHI then divide by zero
        issue("mthi", OP_MTHI, 32'h0000_1234, 0, 1'b0);
        check_eq("mthi.hi", hi, 32'h0000_1234);
        check_eq("mthi.busy", busy, 0);
        issue("divu0", OP_DIVU, 32'd5, 32'd0, 1'b1);
        wait_idle(c, sb);
        check_eq("divu0.busy_cycles", c, 10);
        expect_hilo(32'h0000_1234, 32'h8000_0000);
        check_hilo("divu0");

        issue("divu", OP_DIVU, 32'd100, 32'd7, 1'b1);
        wait_idle(c, sb);
        expect_hilo(32'd2, 32'd14);
        check_hilo("divu");

        issue("op9", 4'd9, 32'hDEAD, 32'd1, 1'b0);
        check_eq("op9.busy", busy, 0);
        expect_hilo(32'd2, 32'd14);
        check_hilo("op9");

        // 5: MTLO and a second MULT while busy are dropped
        issue("mult5", OP_MULT, 32'd6, 32'd7, 1'b1);
        c0 = 0;
        if (busy) c0++;
        drive(OP_MTLO, 32'hAA, 0);
        #1;
        check_eq("mtlo_busy.stall", stall_req, 1);
        step();
        if (busy) c0++;
        drive(OP_MULT, 32'd100, 32'd100);
        #1;
        check_eq("mult_busy.stall", stall_req, 1);
        step();
        drive(OP_MFLO, 0, 0);
        #1;
        check_eq("mflo_busy.committed", mf_data, 32'd14);
        check_eq("mult5.hi_hidden", hi, 32'd2);
        wait_idle(c, sb);
        release_inputs();
        check_eq("mult5.busy_cycles", c0 + c, 5);
        check_eq("mult5.stall_busy", sb, 0);
        expect_hilo(32'd0, 32'd42);
        check_hilo("mult5");
        step();
        check_eq("mult5.no_restart", busy, 0);

`ifdef MDU_CANCEL_EN
        issue("mthi_c", OP_MTHI, 32'h11, 0, 1'b0);
        issue("mtlo_c", OP_MTLO, 32'h22, 0, 1'b0);
        issue("div_c", OP_DIV, 32'd100, 32'd3, 1'b1);
        step();
        step();
        cancel = 1'b1;
        drive(OP_MTHI, 32'h99, 0);
        step();
        cancel = 1'b0;
        release_inputs();
        check_eq("cancel.busy", busy, 0);
        expect_hilo(32'h11, 32'h22);
        check_hilo("cancel");
        repeat (12) step();
        check_eq("cancel.busy_later", busy, 0);
        expect_hilo(32'h11, 32'h22);
        check_hilo("cancel_later");
`endif

        // 6: reset on cycle 3 of a DIV
        issue("div_rst", OP_DIV, 32'd20, 32'd3, 1'b1);
        step();
        step();
        reset = 1'b1;
        step();
        check_eq("rst_mid.busy", busy, 0);
        expect_hilo(32'd0, 32'd0);
        check_hilo("rst_mid");
        reset = 1'b0;
        repeat (12) step();
        check_eq("rst_mid.busy_later", busy, 0);
        expect_hilo(32'd0, 32'd0);
        check_hilo("rst_mid_later");

        issue("multu_post", OP_MULTU, 32'd3, 32'd4, 1'b1);
        wait_idle(c, sb);
        check_eq("multu_post.busy_cycles", c, 5);
        expect_hilo(32'd0, 32'd12);
        check_hilo("multu_post");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
